// File: rtl/rand_lfsr_gen_pkg.sv
// Shared definitions for the LFSR random source: FSM encoding and the single-step
// Fibonacci next-state function used by the unrolled stepper.
package rand_lfsr_gen_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } fsm_state_e;

    localparam int unsigned LFSR_MAX_W = 32;

    // Caller zero-extends the state, so the top bit lands at position width-1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int unsigned width);
        logic fb;
        fb = ^(state & taps);
        return (state >> 1) | ({31'd0, fb} << (width - 32'd1));
    endfunction

endpackage

// File: rtl/rand_lfsr_gen_step_unroll.sv
// Pure combinational STEPS-fold LFSR next-state, built by repeating the single step.
module lfsr_step_unroll
    import rand_lfsr_gen_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
    parameter int              STEPS = 1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    logic [31:0] acc_s;
    logic        unused_acc_s;

    // Apply the single-step function STEPS times on a zero-extended copy.
    always_comb begin
        acc_s = 32'(state_i);
        for (int i = 0; i < STEPS; i++) begin
            acc_s = lfsr_step(acc_s, 32'(TAPS), LFSR_MAX_W'(WIDTH));
        end
    end

    assign state_o      = acc_s[WIDTH-1:0];
    assign unused_acc_s = ^acc_s;

endmodule

// File: rtl/rand_lfsr_gen.sv
// Fibonacci LFSR random source with seed load, valid/ready output, zero-state
// lockup recovery and a period-wrap pulse.
module rand_lfsr_gen
    import rand_lfsr_gen_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int               STEPS = 1,
    parameter int               OUT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             wrap_o,
    output logic             lockup_o
);

    if (WIDTH < 3 || WIDTH > 32 || SEED == '0 || STEPS < 1 || STEPS > WIDTH ||
        OUT_W < 1 || OUT_W > WIDTH) begin : g_param_check
        $error("rand_lfsr_gen: illegal parameter combination");
    end

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_s;
    fsm_state_e       fsm_q;
    logic             out_valid_q;
    logic             wrap_q;
    logic             lockup_q;
    logic             fire_s;
    logic             seed_zero_s;
    logic             state_zero_s;

    lfsr_step_unroll #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_step (
        .state_i (state_q),
        .state_o (step_s)
    );

    assign fire_s       = out_valid_q & out_ready_i;
    assign seed_zero_s  = (seed_in_i == '0);
    assign state_zero_s = (state_q == '0);

    // Next LFSR state; a load wins over a same-cycle fire, RECOVER reseeds.
    always_comb begin
        state_d = state_q;
        case (fsm_q)
            ST_RUN: begin
                if (load_i) begin
                    state_d = seed_in_i;
                end else if (!state_zero_s && fire_s) begin
                    state_d = step_s;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECOVER: begin
                if (load_i && !seed_zero_s) begin
                    state_d = seed_in_i;
                end else begin
                    state_d = SEED;
                end
            end
            default: state_d = SEED;
        endcase
    end

    // State register: plain D flop, no enable, synchronous reset to SEED.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Control FSM with registered handshake and status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= ST_RUN;
            out_valid_q <= 1'b1;
            wrap_q      <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            case (fsm_q)
                ST_RUN: begin
                    if (load_i && seed_zero_s) begin
                        fsm_q       <= ST_RECOVER;
                        out_valid_q <= 1'b0;
                        wrap_q      <= 1'b0;
                        lockup_q    <= 1'b1;
                    end else if (load_i) begin
                        fsm_q       <= ST_RUN;
                        out_valid_q <= 1'b1;
                        wrap_q      <= 1'b0;
                        lockup_q    <= 1'b0;
                    end else if (state_zero_s) begin
                        fsm_q       <= ST_RECOVER;
                        out_valid_q <= 1'b0;
                        wrap_q      <= 1'b0;
                        lockup_q    <= 1'b1;
                    end else begin
                        fsm_q       <= ST_RUN;
                        out_valid_q <= 1'b1;
                        wrap_q      <= fire_s && (step_s == SEED);
                        lockup_q    <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    wrap_q <= 1'b0;
                    if (load_i && seed_zero_s) begin
                        fsm_q       <= ST_RECOVER;
                        out_valid_q <= 1'b0;
                        lockup_q    <= 1'b1;
                    end else begin
                        fsm_q       <= ST_RUN;
                        out_valid_q <= 1'b1;
                        lockup_q    <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= ST_RUN;
                    out_valid_q <= 1'b1;
                    wrap_q      <= 1'b0;
                    lockup_q    <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = state_q[OUT_W-1:0];
    assign wrap_o      = wrap_q;
    assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_rand_lfsr_gen.sv
// Directed bench for rand_lfsr_gen: default, full-width-output and two-step instances
// share one stimulus stream; expected values come from hand values and a step model.
module tb_rand_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] seed_in;
    logic       out_ready;

    logic       v_a, w_a, l_a;
    logic [1:0] d_a;
    logic       v_f, w_f, l_f;
    logic [7:0] d_f;
    logic       v_s, w_s, l_s;
    logic [7:0] d_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rand_lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .STEPS(1), .OUT_W(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .seed_in_i(seed_in), .out_ready_i(out_ready),
        .out_valid_o(v_a), .out_data_o(d_a), .wrap_o(w_a), .lockup_o(l_a));

    rand_lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .STEPS(1), .OUT_W(8)) u_full (
        .clk_i(clk), .rst_i(rst), .load_i(load), .seed_in_i(seed_in), .out_ready_i(out_ready),
        .out_valid_o(v_f), .out_data_o(d_f), .wrap_o(w_f), .lockup_o(l_f));

    rand_lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .STEPS(2), .OUT_W(8)) u_s2 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .seed_in_i(seed_in), .out_ready_i(out_ready),
        .out_valid_o(v_s), .out_data_o(d_s), .wrap_o(w_s), .lockup_o(l_s));

    function automatic logic [7:0] step8(input logic [7:0] s);
        logic fb;
        fb = ^(s & 8'h1D);
        return {fb, s[7:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]   exp_s;
        logic [7:0]   s2_exp;
        logic [7:0]   m;
        logic [255:0] seen;
        int           period;
        int           wraps;

        rst = 1'b1; load = 1'b0; seed_in = 8'h00; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state, no fire yet
        chk("rst_valid",  32'(v_a), 32'd1);
        chk("rst_wrap",   32'(w_a), 32'd0);
        chk("rst_lockup", 32'(l_a), 32'd0);
        chk("rst_state",  32'(d_f), 32'h01);
        chk("rst_data",   32'(d_a), 32'h1);
        chk("rst_s2",     32'(d_s), 32'h01);

        // Test 1/2: free stream, single-step and two-step instances
        out_ready = 1'b1;
        exp_s  = 8'h01;
        s2_exp = 8'h01;
        for (int k = 0; k < 6; k++) begin
            chk("t1_state", 32'(d_f), 32'(exp_s));
            chk("t1_data",  32'(d_a), 32'(exp_s[1:0]));
            chk("t1_wrap",  32'(w_f), 32'd0);
            if (k < 3) chk("t2_s2_state", 32'(d_s), 32'(s2_exp));
            tick();
            exp_s  = step8(exp_s);
            s2_exp = step8(step8(s2_exp));
        end
        chk("t1_hand_0x88", 32'(exp_s), 32'(step8(8'h88)));

        // Test 3: stall holds data and valid, then resumes
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_state", 32'(d_f), 32'(exp_s));
            chk("t3_hold_data",  32'(d_a), 32'(exp_s[1:0]));
            chk("t3_hold_valid", 32'(v_a), 32'd1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_s = step8(exp_s);
            chk("t3_resume", 32'(d_f), 32'(exp_s));
        end

        // Test 5: load beats same-cycle fire
        load = 1'b1; seed_in = 8'h5A;
        tick();
        load = 1'b0;
        chk("t5_load_state", 32'(d_f), 32'h5A);
        chk("t5_load_valid", 32'(v_f), 32'd1);
        tick();
        chk("t5_next", 32'(d_f), 32'h2D);

        // Wrap on a fire into SEED, never on a load of SEED
        load = 1'b1; seed_in = 8'h02;
        tick();
        seed_in = 8'h01;
        tick();
        load = 1'b0;
        chk("load_seed_state",  32'(d_f), 32'h01);
        chk("load_seed_nowrap", 32'(w_f), 32'd0);
        load = 1'b1; seed_in = 8'h02;
        tick();
        load = 1'b0;
        tick();
        chk("fire_wrap_state", 32'(d_f), 32'h01);
        chk("fire_wrap_pulse", 32'(w_f), 32'd1);
        tick();
        chk("wrap_one_cycle",  32'(w_f), 32'd0);

        // Test 4: zero seed triggers lockup and reseed
        load = 1'b1; seed_in = 8'h00;
        tick();
        load = 1'b0;
        chk("t4_valid_low", 32'(v_a), 32'd0);
        chk("t4_lockup",    32'(l_a), 32'd1);
        tick();
        chk("t4_reseed",    32'(d_f), 32'h01);
        chk("t4_valid_hi",  32'(v_a), 32'd1);
        chk("t4_lockup_lo", 32'(l_a), 32'd0);

        // Reset while in RECOVER
        load = 1'b1; seed_in = 8'h00;
        tick();
        load = 1'b0;
        chk("rr_in_recover", 32'(v_f), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_state",  32'(d_f), 32'h01);
        chk("rr_valid",  32'(v_f), 32'd1);
        chk("rr_lockup", 32'(l_f), 32'd0);

        // Test 6: one full period from SEED
        period = 1;
        m = step8(8'h01);
        while (m != 8'h01 && period < 300) begin
            m = step8(m);
            period++;
        end
        seen  = '0;
        wraps = 0;
        m     = 8'h01;
        for (int i = 0; i < period; i++) begin
            chk("t6_state",    32'(d_f), 32'(m));
            chk("t6_nonzero",  32'(d_f != 8'h00), 32'd1);
            chk("t6_distinct", 32'(seen[d_f]), 32'd0);
            seen[d_f] = 1'b1;
            tick();
            m = step8(m);
            if (w_f) wraps++;
            chk("t6_wrap", 32'(w_f), 32'(i == period - 1));
        end
        chk("t6_wrap_count", 32'(wraps), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
